// File: rtl/div_result_bcd_pkg.sv
// Shared constants for the divider-result BCD converter: default sizes,
// FSM state encoding and the double-dabble correction constants.
package div_result_bcd_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int DIGITS_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD    = 4'd3;

endpackage

// File: rtl/div_result_bcd_bcd_dd_step.sv
// One combinational double-dabble iteration: correct every digit >= 5 by +3,
// then shift the scratch left by one with the next binary bit entering bit 0.
module bcd_dd_step
  import div_result_bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic [4*DIGITS-1:0] scratch,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] scratch_next
);

  logic [4*DIGITS-1:0] corrected;

  always_comb begin
    corrected = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      // 4-bit add only: no carry may ripple into the next digit
      if (scratch[4*i +: 4] >= BCD_THRESH)
        corrected[4*i +: 4] = scratch[4*i +: 4] + BCD_ADD;
    end
    scratch_next = {corrected[4*DIGITS-2:0], bit_in};
  end

endmodule

// File: rtl/div_result_bcd.sv
// Converts the divider's quotient and remainder to packed BCD in parallel,
// one binary bit per clock, with a single start/done handshake per result.
module div_result_bcd
  import div_result_bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    Quotient,
  input  logic [WIDTH-1:0]    Reminder,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is sampled only while state==IDLE; a start seen while busy
  // is dropped. done pulses for one cycle exactly when q_bcd/r_bcd update.
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    q_bin, r_bin;
  logic [4*DIGITS-1:0] q_scr, r_scr;
  logic [4*DIGITS-1:0] q_next, r_next;

  bcd_dd_step #(.DIGITS(DIGITS)) u_q_step (
    .scratch      (q_scr),
    .bit_in       (q_bin[WIDTH-1]),
    .scratch_next (q_next)
  );

  bcd_dd_step #(.DIGITS(DIGITS)) u_r_step (
    .scratch      (r_scr),
    .bit_in       (r_bin[WIDTH-1]),
    .scratch_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q_bcd <= '0;
      r_bcd <= '0;
      cnt   <= '0;
      q_bin <= '0;
      r_bin <= '0;
      q_scr <= '0;
      r_scr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_bin <= Quotient;
            r_bin <= Reminder;
            q_scr <= '0;
            r_scr <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          q_scr <= q_next;
          r_scr <= r_next;
          q_bin <= {q_bin[WIDTH-2:0], 1'b0};
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
          // Final iteration publishes the corrected-and-shifted value directly
          if (cnt == CW'(1)) begin
            q_bcd <= q_next;
            r_bcd <= r_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: vector table, randomized conversions
// against a decimal-arithmetic model, and multi-cycle handshake/reset corners.
module tb_div_result_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Reminder;
  logic          busy;
  logic          done;
  logic [BW-1:0] q_bcd;
  logic [BW-1:0] r_bcd;

  int n_checks;
  int n_fail;
  logic [2*BW-1:0] exp_q[$];

  div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .Quotient (Quotient),
    .Reminder (Reminder),
    .busy     (busy),
    .done     (done),
    .q_bcd    (q_bcd),
    .r_bcd    (r_bcd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [BW-1:0]    eq;
    logic [BW-1:0]    er;
  } vec_t;

  vec_t vecs[5];

  // Reference: decimal digits by plain division
  function automatic logic [BW-1:0] to_bcd(int v);
    logic [BW-1:0] res;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one start pulse, wait for done, compare latency and result.
  task automatic run_one(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input string name);
    logic [2*BW-1:0] exp;
    logic [BW-1:0] prev_q, prev_r;
    int n;
    bit seen;
    prev_q = q_bcd;
    prev_r = r_bcd;
    Quotient = q;
    Reminder = r;
    start = 1'b1;
    exp_q.push_back({to_bcd(int'(q)), to_bcd(int'(r))});
    @(negedge clk);
    start = 1'b0;
    Quotient = WIDTH'($urandom);
    Reminder = WIDTH'($urandom);
    check({name, " busy"}, 32'(busy), 32'd1);
    check({name, " hold"}, 32'({q_bcd, r_bcd}), 32'({prev_q, prev_r}));
    n = 0;
    seen = 1'b0;
    while (n < 2 * WIDTH + 4 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check({name, " done timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      check({name, " latency"}, 32'(n), 32'(WIDTH));
      check({name, " q_bcd"}, 32'(q_bcd), 32'(exp[2*BW-1:BW]));
      check({name, " r_bcd"}, 32'(r_bcd), 32'(exp[BW-1:0]));
      @(negedge clk);
      check({name, " done width"}, 32'({done, busy}), 32'd0);
    end
  endtask

  initial begin
    int n, dones, first_n;
    logic [BW-1:0] got_q, got_r;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    Quotient = '0;
    Reminder = '0;

    vecs[0] = '{q: 8'd7,   r: 8'd14, eq: 12'h007, er: 12'h014};
    vecs[1] = '{q: 8'd255, r: 8'd0,  eq: 12'h255, er: 12'h000};
    vecs[2] = '{q: 8'd0,   r: 8'd99, eq: 12'h000, er: 12'h099};
    vecs[3] = '{q: 8'd100, r: 8'd9,  eq: 12'h100, er: 12'h009};
    vecs[4] = '{q: 8'd199, r: 8'd59, eq: 12'h199, er: 12'h059};

    repeat (2) @(negedge clk);
    check("reset state", 32'({busy, done, q_bcd, r_bcd}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no start", 32'({busy, done}), 32'd0);

    // table: constant expectations, also cross-checks the model
    for (int i = 0; i < 5; i++) begin
      check($sformatf("model q %0d", i), 32'(to_bcd(int'(vecs[i].q))), 32'(vecs[i].eq));
      run_one(vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table q", i), 32'(q_bcd), 32'(vecs[i].eq));
      check($sformatf("vec%0d table r", i), 32'(r_bcd), 32'(vecs[i].er));
    end

    // randomized
    for (int i = 0; i < 20; i++) begin
      run_one(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
              $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start while busy is ignored
    Quotient = 8'd100; Reminder = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; dones = 0; first_n = 0; got_q = '0; got_r = '0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        Quotient = 8'd200; Reminder = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_n = n; got_q = q_bcd; got_r = r_bcd;
        end
      end
    end
    check("busy start dones", 32'(dones), 32'd1);
    check("busy start latency", 32'(first_n), 32'(WIDTH));
    check("busy start q", 32'(got_q), 32'h100);
    check("busy start r", 32'(got_r), 32'h009);

    // reset mid-conversion
    Quotient = 8'd123; Reminder = 8'd123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort state", 32'({busy, done, q_bcd, r_bcd}), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    check("abort outputs", 32'({q_bcd, r_bcd}), 32'd0);
    run_one(8'd45, 8'd45, "post reset");

    // back-to-back with start held high
    Quotient = 8'd58; Reminder = 8'd3; start = 1'b1;
    @(negedge clk);
    Quotient = 8'd64; Reminder = 8'd16;
    n = 0;
    while (n < 2 * WIDTH + 4 && !done) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", 32'(n), 32'(WIDTH));
    check("b2b first q", 32'(q_bcd), 32'h058);
    check("b2b first r", 32'(r_bcd), 32'h003);
    n = 0;
    @(negedge clk);
    n++;
    start = 1'b0;
    check("b2b recapture busy", 32'(busy), 32'd1);
    while (n < 2 * WIDTH + 4 && !done) begin
      @(negedge clk);
      n++;
    end
    check("b2b second spacing", 32'(n), 32'(WIDTH + 1));
    check("b2b second q", 32'(q_bcd), 32'h064);
    check("b2b second r", 32'(r_bcd), 32'h016);
    @(negedge clk);
    check("b2b end idle", 32'({busy, done}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Downstream stage of the sequential divider circuit. Consumes its 8-bit Quotient and Reminder outputs.
- Converts both values to packed BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Feeds the display/readout logic. A single start/done handshake per result. Both operands are converted in parallel.

Parameters:
- WIDTH, 8, bit width of the quotient and remainder inputs.
- DIGITS, 3, number of BCD digits per operand. Must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request conversion of the current inputs; sampled only in IDLE.
- Quotient  input  WIDTH  quotient from the divider.
- Reminder  input  WIDTH  remainder from the divider.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when q_bcd/r_bcd update.
- q_bcd  output  4*DIGITS  packed BCD quotient, most significant digit in the top nibble.
- r_bcd  output  4*DIGITS  packed BCD remainder.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, q_bcd=0, r_bcd=0, counter=0, scratch registers=0.
  - Reset mid-conversion aborts it. No done pulse follows.
- States: IDLE, SHIFT. done is a registered pulse, not a state.
- IDLE:
  - On an edge with start=1: capture Quotient/Reminder into shift registers, clear both BCD scratch registers, load counter=WIDTH, go to SHIFT.
  - start=0: remain in IDLE. Outputs hold.
- SHIFT (busy=1), on each edge, per operand:
  - Every scratch digit >=5 gets +3 (4-bit add, no carry into the neighbouring digit).
  - Then {scratch, binary} shifts left by 1, binary MSB entering scratch bit 0.
  - Counter decrements.
- Last shift (counter==1 before the edge):
  - The corrected-and-shifted result is written directly to q_bcd/r_bcd on that same edge.
  - done=1 and state=IDLE on that edge.
- Timing:
  - Capture edge E0, shift edges E1..E_WIDTH. busy is high from E0 to E_WIDTH.
  - done is high for exactly the cycle after E_WIDTH and clears at the next edge.
  - Start-to-done latency: WIDTH clocks after the capture edge.
- start while busy: ignored. It is not queued.
- start high in the done cycle: state is already IDLE, so it is accepted and the next capture occurs at that edge.
- Inputs may change freely after the capture edge. Only captured values are converted.
- q_bcd/r_bcd hold their last value until the next completion, including while busy.
- Range: all inputs 0..2^WIDTH-1 are legal. For WIDTH=8 the maximum is 255 -> 0x255. No overflow path exists for legal parameters.

Decomposition:
- Shared package holds:
  - WIDTH and DIGITS defaults.
  - The state encoding constants IDLE/SHIFT.
  - The BCD correction threshold (5) and offset (3).
- One sub-module, bcd_dd_step:
  - Combinational single iteration (per-digit add-3, then shift-in of one binary bit).
  - Instantiated twice, once for the quotient and once for the remainder.
  - The top level owns the FSM, the counter and the registers.

Test Plan:
1. Quotient=7, Reminder=14 (the 133/17 divider result), start pulsed 1 cycle -> busy for 8 cycles; done pulse; q_bcd=0x007, r_bcd=0x014.
2. Quotient=255, Reminder=0 -> q_bcd=0x255, r_bcd=0x000. Quotient=0, Reminder=99 -> q_bcd=0x000, r_bcd=0x099.
3. Start with Q=100, R=9; change inputs to 200/1 and pulse start at cycle 3 of busy -> second start ignored; result 0x100/0x009; exactly one done.
4. rst_n=0 at shift cycle 4 of a conversion of 123 -> busy=0, done never pulses, q_bcd=r_bcd=0 next cycle. A fresh start of 45 after release -> 0x045.
5. Back-to-back: start held high continuously with Q=58, R=3, then Q=64, R=16 -> first done gives 0x058/0x003; the second capture happens in the done cycle; the second done exactly WIDTH+1 clocks later gives 0x064/0x016.
